// File: rtl/wordcount_pkg.sv
// Shared definitions for the word-count accumulator array and its read-out path.
package wordcount_pkg;
  localparam int DEFAULT_ADDR_WIDTH = 14;
  // Field positions inside a 64-bit array word.
  localparam int KEY_LSB   = 32;
  localparam int COUNT_LSB = 0;

  // Host-facing record. The index is carried at full address-bus width.
  typedef struct packed {
    logic [31:0] key;
    logic [31:0] count;
    logic [31:0] index;
  } wc_rec_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DRAIN,
    ST_DONE
  } dump_state_t;
endpackage

// File: rtl/dump_fifo2.sv
// Two-entry synchronous FIFO. The head entry sits in its own register, so the
// output is flop-driven and holds steady until it is popped.
module dump_fifo2 #(
  parameter int W = 96
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         valid_o,
  output logic [1:0]   count_o
);
  logic [W-1:0] head_q, head_d, tail_q, tail_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         pop;

  assign pop     = pop_i && (cnt_q != 2'd0);
  assign dout_o  = head_q;
  assign valid_o = (cnt_q != 2'd0);
  assign count_o = cnt_q;

  // Next head/tail/occupancy for every push/pop combination.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (pop && push_i) begin
      if (cnt_q == 2'd1) begin
        head_d = din_i;
      end else begin
        head_d = tail_q;
        tail_d = din_i;
      end
    end else if (pop) begin
      head_d = tail_q;
      cnt_d  = cnt_q - 2'd1;
    end else if (push_i && cnt_q != 2'd2) begin
      if (cnt_q == 2'd0) head_d = din_i;
      else               tail_d = din_i;
      cnt_d = cnt_q + 2'd1;
    end
  end

  // Storage and occupancy registers; reset flushes the queue.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// File: rtl/accum_dump.sv
// Scans the accumulator array in ascending address order and streams occupied
// entries out over valid/ready. Reads are only issued when the output FIFO is
// guaranteed room for the returning word, so no read data is ever dropped.
module accum_dump
  import wordcount_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter bit SKIP_ZERO  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [31:0]           rd_addr_o,
  input  logic [63:0]           rd_q_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [31:0]           out_key_o,
  output logic [31:0]           out_count_o,
  output logic [ADDR_WIDTH-1:0] out_index_o,
  output logic [ADDR_WIDTH:0]   entry_cnt_o
);
  localparam int W = 64 + ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] ENT_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

  dump_state_t           state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] ret_idx_q, last_addr_q, addr;
  logic [ADDR_WIDTH:0]   entry_q;
  logic                  inflight_q;
  logic                  issue, pop, push, accept;
  logic [2:0]            occ;
  logic [31:0]           ret_cnt;
  logic [1:0]            fcnt;
  logic [W-1:0]          fdout;

  assign pop     = out_valid_o && out_ready_i;
  // Occupancy plus the word already on its way must leave a free slot after
  // this cycle's pop for the read we are about to issue.
  assign occ     = {1'b0, fcnt} + {2'b0, inflight_q};
  assign issue   = (state_q == ST_SCAN) && (occ < (3'd2 + {2'b0, pop}));
  assign accept  = (state_q == ST_IDLE) && start_i;
  assign ret_cnt = rd_q_i[COUNT_LSB +: 32];
  assign push    = inflight_q && !(SKIP_ZERO && ret_cnt == 32'd0);

  assign addr      = (state_q == ST_IDLE) ? '0 : (issue ? idx_q : last_addr_q);
  assign rd_addr_o = {{(32-ADDR_WIDTH){1'b0}}, addr};
  assign busy_o    = (state_q != ST_IDLE);
  assign done_o    = (state_q == ST_DONE);
  assign entry_cnt_o = entry_q;
  assign {out_key_o, out_count_o, out_index_o} = fdout;

  dump_fifo2 #(.W(W)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .din_i   ({rd_q_i[KEY_LSB +: 32], ret_cnt, ret_idx_q}),
    .pop_i   (pop),
    .dout_o  (fdout),
    .valid_o (out_valid_o),
    .count_o (fcnt)
  );

  // Scan sequencing: next state and next read index.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: if (start_i) begin
        state_d = ST_SCAN;
        idx_d   = '0;
      end
      ST_SCAN: if (issue) begin
        idx_d = idx_q + 1'b1;
        if (idx_q == {ADDR_WIDTH{1'b1}}) state_d = ST_DRAIN;
      end
      ST_DRAIN: if (!inflight_q && fcnt == 2'd0) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State, in-flight read tracking and the record counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      inflight_q  <= 1'b0;
      ret_idx_q   <= '0;
      last_addr_q <= '0;
      entry_q     <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      inflight_q <= issue;
      if (issue) begin
        ret_idx_q   <= idx_q;
        last_addr_q <= idx_q;
      end else if (accept) begin
        last_addr_q <= '0;
      end
      if (accept)                         entry_q <= '0;
      else if (push && entry_q != ENT_MAX) entry_q <= entry_q + 1'b1;
    end
  end
endmodule

// File: doc/accum_dump.md
# accum_dump

Read-out stage downstream of the word-count accumulator array. After accumulation finishes, `accum_dump` scans every array address in ascending order through the array's 1-cycle-latency read port and streams each occupied entry (key word, count, index) on a valid/ready interface toward the host DMA/result writer. It owns the array read address while busy; the top level must hold the accumulator `we` low whenever `busy` is high.

## Interface
- `ADDR_WIDTH`, 14, array depth is 2^ADDR_WIDTH entries
- `SKIP_ZERO`, 1, 1: drop entries whose count field is 0; 0: emit every entry
- `clk` in 1 clock; all logic on rising edge
- `reset` in 1 reset, synchronous, active-high; clock clk
- `start` in 1 begin scan; sampled only in IDLE
- `busy` out 1 high from the cycle after accepted `start` until `done`, inclusive
- `done` out 1 one-cycle pulse at scan completion
- `rd_addr` out 32 array read address; bits [31:ADDR_WIDTH] always 0
- `rd_q` in 64 array read data, valid 1 cycle after `rd_addr`
- `out_valid` out 1 record available
- `out_ready` in 1 consumer accepts record when valid & ready
- `out_key` out 32 `rd_q[63:32]` of the entry
- `out_count` out 32 `rd_q[31:0]` of the entry
- `out_index` out ADDR_WIDTH array address of the entry
- `entry_cnt` out ADDR_WIDTH+1 records pushed during the current/last scan

## Operation
- States: IDLE, SCAN, DRAIN, DONE.
- IDLE: `rd_addr`=0. `start`=1 → SCAN, idx←0, `entry_cnt`←0. `start` in any other state ignored.
- SCAN: each cycle a read is issued at idx iff credit holds: fifo_count − pop + inflight < 2 (pop = this cycle's handshake). On issue, `rd_addr`=idx, idx+1, inflight←1 for next cycle. Issue at idx = 2^ADDR_WIDTH−1 → DRAIN.
- Return: the cycle after an issue, `rd_q` and the issued index are captured; pushed into the output FIFO unless SKIP_ZERO=1 and `rd_q[31:0]`=0. Each push increments `entry_cnt` (saturates at 2^ADDR_WIDTH, cannot overflow).
- DRAIN: no issues; when inflight=0 and FIFO empty → DONE.
- DONE: `done`=1 for exactly one cycle → IDLE. `busy` drops with IDLE.
- Output FIFO: 2 entries, registered outputs; `out_*` held stable while `out_valid`=1 and `out_ready`=0. Credit rule guarantees no push to a full FIFO and no lost read data.
- Reset mid-scan: FIFO flushed, in-flight read discarded, state IDLE, no `done`.

## Timing
- Reset values: `busy`=0, `done`=0, `out_valid`=0, `rd_addr`=0, `out_key`/`out_count`/`out_index`=0, `entry_cnt`=0.
- `start` at cycle 0 → SCAN at cycle 1, `rd_addr`=0 at cycle 1, data captured cycle 2, earliest `out_valid` cycle 3.
- With `out_ready` held 1: one read issued per cycle; full scan throughput 1 entry/cycle; `done` no later than 2^ADDR_WIDTH+4 cycles after `start`.
- `out_ready`=0: at most 2 records buffered; issue stalls, `rd_addr` holds last issued value.
- Records leave strictly in ascending `out_index` order, no duplicates.

## Structure
- Shared package `wordcount_pkg`: record typedef (key 32, count 32, index), `COUNT_LSB`/`KEY_LSB` field positions of the 64-bit array word, default ADDR_WIDTH.
- One sub-module: `dump_fifo2`, 2-entry synchronous FIFO with count output, parameterized by record type width; flushed by `reset`.

## Test plan
- ADDR_WIDTH=4, SKIP_ZERO=1, all entries 0, `out_ready`=1 → no `out_valid`, `done` pulse ≤20 cycles after start, `entry_cnt`=0.
- ADDR_WIDTH=4, index 3 = {0x0000000A, 5}, index 15 = {0x0000000B, 1}, rest 0 → two records (3,0xA,5) then (15,0xB,1), `entry_cnt`=2.
- ADDR_WIDTH=4, SKIP_ZERO=0, index i holds count i, random `out_ready` (50%) → 16 records, indices 0..15 in order, counts match, outputs stable under stall.
- Pulse `start` again at cycles 5 and 10 of a scan → ignored; exactly one `done`, one record set.
- Assert `reset` at cycle 8 of a scan with `out_ready`=0 → next cycle `out_valid`=0, `busy`=0, no `done`; new `start` produces full correct scan.
- ADDR_WIDTH=14, index 16383 count 7 only → single record index 16383, `done` ≤16388 cycles after start.
